led_bar_meter: RTL and testbench

Consumer end of the audio LED-queue readout path. It accepts each burst of magnitude samples that the sample queue streams out under its `sequencing` flag. It accumulates the burst, divides by the sample count with a serial divider, and drives an 8-segment logarithmic LED bar with peak-hold and decay. One result is produced per burst; one burst is expected per written audio sample.

---
 rtl/led_meter_pkg.sv | 42 ++++
 rtl/ser_div.sv | 85 ++++++++
 rtl/led_bar_meter.sv | 161 ++++++++++++++++
 tb/tb_led_bar_meter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_meter_pkg.sv
`default_nettype none
// ============================================================================
// led_meter_pkg : shared FSM states, bar thresholds and bar helpers
// Revision      : 1.0
// ============================================================================
package led_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_UPDATE = 2'd3
  } meter_st_t;

  localparam int N_SEG = 8;

  // Segment k lights when the average reaches 2^(7+k).
  localparam logic [N_SEG-1:0][15:0] LED_THRESH = {
    16'h4000, 16'h2000, 16'h1000, 16'h0800,
    16'h0400, 16'h0200, 16'h0100, 16'h0080
  };

  function automatic logic [N_SEG-1:0] thermo(input logic [3:0] level);
    logic [N_SEG-1:0] bar;
    bar = '0;
    for (int k = 0; k < N_SEG; k++) begin
      if (level > 4'(k)) bar[k] = 1'b1;
    end
    return bar;
  endfunction

  function automatic logic [3:0] bar_level(input logic [15:0] value);
    logic [3:0] lvl;
    lvl = '0;
    for (int k = 0; k < N_SEG; k++) begin
      if (value >= LED_THRESH[k]) lvl = lvl + 4'd1;
    end
    return lvl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_div.sv
`default_nettype none
// ============================================================================
// ser_div : serial restoring divider, one quotient bit per clock
// Revision: 1.0
// ============================================================================
module ser_div #(
  parameter int DIVIDEND_W = 26,
  parameter int DIVISOR_W  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_BITS = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] quo_q, quo_d, quo_src;
  logic [DIVISOR_W-1:0]  rem_q, rem_d, rem_src;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d, dvs_src;
  logic [DIVISOR_W:0]    trial;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  // The start cycle already resolves the first quotient bit from the raw
  // operands, so the whole divide finishes DIVIDEND_W edges after start.
  always_comb begin
    quo_src = start ? dividend : quo_q;
    rem_src = start ? '0 : rem_q;
    dvs_src = start ? divisor : dvs_q;
    trial   = {rem_src, quo_src[DIVIDEND_W-1]};

    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    if (start || busy_q) begin
      dvs_d = dvs_src;
      if (trial >= {1'b0, dvs_src}) begin
        rem_d = DIVISOR_W'(trial - {1'b0, dvs_src});
        quo_d = {quo_src[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIVISOR_W-1:0];
        quo_d = {quo_src[DIVIDEND_W-2:0], 1'b0};
      end
    end

    if (start) begin
      cnt_d  = CNT_BITS'(DIVIDEND_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d  = cnt_q - CNT_BITS'(1);
      busy_d = (cnt_q != CNT_BITS'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // done marks the final iteration; quotient is complete on the next cycle.
  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CNT_BITS'(1));
  assign quotient = quo_q;

endmodule
`default_nettype wire

// File: rtl/led_bar_meter.sv
`default_nettype none
// ============================================================================
// led_bar_meter : burst averager driving a log LED bar with peak-hold/decay
// Revision      : 1.0
// ============================================================================
module led_bar_meter #(
  parameter int PEAK_HOLD = 4,
  parameter int CNT_W     = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seq,
  input  logic [15:0] smpl,
  input  logic        clr_ovr,
  output logic [15:0] avg,
  output logic        avg_vld,
  output logic [7:0]  led,
  output logic        ovr
);

  import led_meter_pkg::*;

  localparam int SUM_W  = CNT_W + 15;
  localparam int HOLD_W = (PEAK_HOLD < 1) ? 1 : $clog2(PEAK_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meter_st_t          state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        avg_q, avg_d;
  logic               avg_vld_q, avg_vld_d;
  logic [7:0]         led_q, led_d;
  logic               ovr_q, ovr_d;
  logic [3:0]         peak_q, peak_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               drop_q, drop_d;

  logic               ovr_set;
  logic               div_start, div_busy, div_done;
  logic [SUM_W-1:0]   quotient;
  logic [3:0]         level;
  logic               unused_ok;

  ser_div #(
    .DIVIDEND_W (SUM_W),
    .DIVISOR_W  (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_q),
    .divisor  (count_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    count_d   = count_q;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;
    led_d     = led_q;
    peak_d    = peak_q;
    hold_d    = hold_q;
    drop_d    = drop_q;
    ovr_set   = 1'b0;
    div_start = 1'b0;
    level     = '0;

    case (state_q)
      ST_IDLE: begin
        if (seq && !drop_q) begin
          sum_d   = SUM_W'(smpl[14:0]);
          count_d = CNT_W'(1);
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (seq) begin
          if (count_q == CNT_MAX) begin
            ovr_set = 1'b1;
          end else begin
            sum_d   = sum_q + SUM_W'(smpl[14:0]);
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        avg_d = {1'b0, quotient[14:0]};
        level = bar_level(avg_d);
        if (level >= peak_q) begin
          peak_d = level;
          hold_d = HOLD_W'(PEAK_HOLD);
        end else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else begin
          peak_d = ((peak_q - 4'd1) > level) ? (peak_q - 4'd1) : level;
        end
        led_d = thermo(level);
        if (peak_d != 4'd0) led_d[3'(peak_d - 4'd1)] = 1'b1;
        avg_vld_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A burst arriving while busy is swallowed whole, up to its falling edge.
    if (!seq) begin
      drop_d = 1'b0;
    end else if (state_q == ST_DIVIDE || state_q == ST_UPDATE) begin
      drop_d = 1'b1;
      if (!drop_q) ovr_set = 1'b1;
    end

    ovr_d = ovr_set | (ovr_q & ~clr_ovr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sum_q     <= '0;
      count_q   <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      led_q     <= '0;
      ovr_q     <= 1'b0;
      peak_q    <= '0;
      hold_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
      led_q     <= led_d;
      ovr_q     <= ovr_d;
      peak_q    <= peak_d;
      hold_q    <= hold_d;
      drop_q    <= drop_d;
    end
  end

  assign avg     = avg_q;
  assign avg_vld = avg_vld_q;
  assign led     = led_q;
  assign ovr     = ovr_q;

  // Sample MSB is ignored and the quotient never exceeds 15 bits.
  assign unused_ok = &{1'b0, smpl[15], div_busy, quotient[SUM_W-1:15]};

endmodule
`default_nettype wire

// File: tb/tb_led_bar_meter.sv
`default_nettype none
// tb_led_bar_meter: random and directed bursts checked against an arithmetic
// model of burst average, log bar level and peak-hold/decay.
module tb_led_bar_meter;

  localparam int P_HOLD  = 2;
  localparam int CW      = 11;
  localparam int MAX_CNT = (1 << CW) - 1;
  localparam int LATENCY = 28;
  localparam logic [7:0] PK_TAB [11] = '{8'hFF, 8'h80, 8'h80, 8'h40, 8'h20,
                                         8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seq;
  logic [15:0] smpl;
  logic        clr_ovr;
  logic [15:0] avg;
  logic        avg_vld;
  logic [7:0]  led;
  logic        ovr;

  int          n_tests = 0;
  int          n_fail  = 0;
  longint      m_sum;
  int          m_cnt;
  int          m_peak;
  int          m_hold;
  bit          m_ovr;
  logic [15:0] obs_avg;
  logic [7:0]  obs_led;

  always #5 clk = ~clk;

  led_bar_meter #(.PEAK_HOLD(P_HOLD), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seq     (seq),
    .smpl    (smpl),
    .clr_ovr (clr_ovr),
    .avg     (avg),
    .avg_vld (avg_vld),
    .led     (led),
    .ovr     (ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_peak = 0;
    m_hold = 0;
    m_ovr  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    seq     = 1'b0;
    clr_ovr = 1'b0;
    smpl    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic start_burst();
    m_sum = 0;
    m_cnt = 0;
  endtask

  task automatic push(input logic [15:0] s);
    seq  = 1'b1;
    smpl = s;
    if (m_cnt < MAX_CNT) begin
      m_sum += longint'(s[14:0]);
      m_cnt++;
    end else begin
      m_ovr = 1'b1;
    end
    @(negedge clk);
  endtask

  // cyc0 = how many cycles after the last accepted sample we already are.
  task automatic end_burst(input string tag, input int cyc0);
    int cyc;
    int e_avg;
    int lvl;
    int e_led;
    seq     = 1'b0;
    clr_ovr = 1'b0;
    smpl    = 16'($urandom);
    cyc     = cyc0;
    while (avg_vld !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    e_avg = int'(m_sum / longint'(m_cnt));
    lvl = 0;
    for (int k = 0; k < 8; k++) if (e_avg >= (1 << (7 + k))) lvl++;
    if (lvl >= m_peak) begin
      m_peak = lvl;
      m_hold = P_HOLD;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      m_peak = (m_peak - 1 > lvl) ? m_peak - 1 : lvl;
    end
    e_led = (1 << lvl) - 1;
    if (m_peak > 0) e_led |= (1 << (m_peak - 1));
    obs_avg = avg;
    obs_led = led;
    check({tag, "_lat"}, 32'(cyc), 32'(LATENCY));
    check({tag, "_avg"}, 32'(avg), 32'(e_avg));
    check({tag, "_led"}, 32'(led), 32'(e_led));
    check({tag, "_ovr"}, 32'(ovr), 32'(m_ovr));
    @(negedge clk);
    check({tag, "_vld_pulse"}, 32'(avg_vld), 32'd0);
  endtask

  task automatic watch_quiet(input string tag);
    int n;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (avg_vld === 1'b1) n++;
    end
    check({tag, "_no_vld"}, 32'(n), 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; seq = 1'b0; clr_ovr = 1'b0; smpl = '0;
    model_reset();
    // Reset held while inputs toggle randomly
    for (int i = 0; i < 6; i++) begin
      seq = 1'($urandom); smpl = 16'($urandom); clr_ovr = 1'($urandom);
      @(negedge clk);
    end
    check("rst_led", 32'(led), 32'd0);
    check("rst_avg", 32'(avg), 32'd0);
    check("rst_vld", 32'(avg_vld), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    seq = 1'b0; clr_ovr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Long flat burst
    start_burst();
    repeat (1021) push(16'h0400);
    end_burst("flat", 1);
    check("flat_avg_lit", 32'(obs_avg), 32'h0400);
    check("flat_led_lit", 32'(obs_led), 32'h0F);

    // Small burst, then full-scale burst with bit 15 set
    do_reset();
    start_burst();
    push(16'd1); push(16'd2); push(16'd4);
    end_burst("small", 1);
    check("small_avg_lit", 32'(obs_avg), 32'd2);
    check("small_led_lit", 32'(obs_led), 32'h00);
    start_burst();
    repeat (5) push(16'hFFFF);
    end_burst("full", 1);
    check("full_avg_lit", 32'(obs_avg), 32'h7FFF);
    check("full_led_lit", 32'(obs_led), 32'hFF);

    // Peak hold and decay
    do_reset();
    start_burst();
    repeat (4) push({1'($urandom), 15'h7FFF});
    end_burst("pk0", 1);
    check("pk0_lit", 32'(obs_led), 32'(PK_TAB[0]));
    for (int i = 1; i < 11; i++) begin
      start_burst();
      push({1'($urandom), 15'h0000});
      end_burst($sformatf("pk%0d", i), 1);
      check($sformatf("pk%0d_lit", i), 32'(obs_led), 32'(PK_TAB[i]));
    end

    // Burst arriving during the divide is dropped
    do_reset();
    start_burst();
    repeat (6) push(16'($urandom));
    seq = 1'b0;
    repeat (10) @(negedge clk);
    check("drop_pre_ovr", 32'(ovr), 32'd0);
    seq = 1'b1; smpl = 16'($urandom);
    @(negedge clk);
    check("drop_ovr", 32'(ovr), 32'd1);
    m_ovr = 1'b1;
    repeat (3) begin
      smpl = 16'($urandom);
      @(negedge clk);
    end
    end_burst("drop_first", 15);
    start_burst();
    repeat (9) push(16'($urandom));
    end_burst("drop_third", 1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    m_ovr = 1'b0;
    check("clr_ovr", 32'(ovr), 32'd0);

    // Reset mid-accumulate and mid-divide
    do_reset();
    start_burst();
    repeat (5) push(16'($urandom));
    rst_n = 1'b0; seq = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; model_reset();
    watch_quiet("rst_accum");
    start_burst();
    repeat (8) push(16'($urandom));
    seq = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; model_reset();
    watch_quiet("rst_div");
    start_burst();
    repeat (20) push(16'h0100);
    end_burst("post_rst", 1);
    check("post_rst_avg_lit", 32'(obs_avg), 32'h0100);
    check("post_rst_led_lit", 32'(obs_led), 32'h03);

    // Counter saturation; clear and set collide on the last sample
    do_reset();
    start_burst();
    for (int j = 0; j < MAX_CNT + 2; j++) begin
      if (j == MAX_CNT + 1) clr_ovr = 1'b1;
      push(16'($urandom));
    end
    end_burst("sat", 1);

    // Random bursts of varied length and magnitude
    do_reset();
    for (int b = 0; b < 8; b++) begin
      int n;
      int sh;
      n  = $urandom_range(1, 60);
      sh = $urandom_range(0, 12);
      start_burst();
      for (int j = 0; j < n; j++) push(16'($urandom) >> sh);
      end_burst($sformatf("rnd%0d", b), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
